pixel_array_ctrl: RTL

PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

---
 rtl/pixel_ctrl_pkg.sv | 19 +
 rtl/pixel_array_ctrl_if.sv | 14 +
 rtl/adc_counter.sv | 31 +++
 rtl/pixel_array_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default timing for the pixel-array capture controller.
// Phase lengths are counted by one 16-bit down-counter, wide enough for exp_time.
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ1   = 3'd4,
        READ2   = 3'd5
    } state_t;

    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_READ_CYCLES  = 5;
    localparam int DEF_DW           = 8;
    localparam int PHASE_W          = 16;

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Capture request/result channel between a frame consumer and pixel_array_ctrl.
// start is a level request taken only while busy=0; frame_valid pulses for one cycle per frame.
interface pixel_array_ctrl_if #(
    parameter int DW = 8
);
    logic            start;
    logic [15:0]     exp_time;
    logic            busy;
    logic [4*DW-1:0] frame_data;
    logic            frame_valid;

    modport master (output start, exp_time, input busy, frame_data, frame_valid);
    modport slave  (input start, exp_time, output busy, frame_data, frame_valid);
endinterface

// File: rtl/adc_counter.sv
// Single-slope ADC counter: clear has priority, otherwise count up while enabled.
module adc_counter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    output logic [DW-1:0] count
);
    logic [DW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + {{(DW-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame capture sequencer: erase, expose, ramp-convert, then read the pixel data back.
// All strobes are flops loaded from the next state so they never glitch.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int DW           = DEF_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    pixel_array_ctrl_if.slave        cap,
    output logic                     erase,
    output logic                     expose,
    output logic                     read1,
    output logic                     read2,
    output logic                     ramp_en,
    output logic [DW-1:0]            cnt_out,
    output logic                     cnt_oe,
    input  logic [DW-1:0]            data1,
    input  logic [DW-1:0]            data2,
    input  logic [DW-1:0]            data3,
    input  logic [DW-1:0]            data4,
    output state_t                   dbg_state
);
    localparam logic [PHASE_W-1:0] ONE       = 1;
    localparam logic [PHASE_W-1:0] ERASE_LEN = PHASE_W'(ERASE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] READ_LEN  = PHASE_W'(READ_CYCLES - 1);

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  exp_q, exp_d;
    logic [2*DW-1:0]     d12_q, d12_d;
    logic [4*DW-1:0]     frame_data_q, frame_data_d;
    logic                frame_valid_q, frame_valid_d;
    logic                erase_q, erase_d, expose_q, expose_d;
    logic                read1_q, read1_d, read2_q, read2_d;
    logic                ramp_q, ramp_d, busy_q, busy_d;
    logic                adc_clear, adc_en, cnt_last;
    logic [DW-1:0]       adc_count;

    assign cnt_last = &adc_count;

    // phase_q holds remaining cycles minus one; a phase ends when it reads zero.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        exp_d         = exp_q;
        d12_d         = d12_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        adc_clear     = 1'b1;
        adc_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap.start) begin
                    state_d = ERASE;
                    phase_d = ERASE_LEN;
                    exp_d   = cap.exp_time;
                end
            end
            ERASE: begin
                if (phase_q == '0) begin
                    state_d = EXPOSE;
                    phase_d = (exp_q == '0) ? '0 : exp_q - ONE;
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            EXPOSE: begin
                if (phase_q == '0) begin
                    state_d = CONVERT;
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            CONVERT: begin
                adc_clear = cnt_last;
                adc_en    = !cnt_last;
                if (cnt_last) begin
                    state_d = READ1;
                    phase_d = READ_LEN;
                end
            end
            READ1: begin
                if (phase_q == '0) begin
                    state_d = READ2;
                    phase_d = READ_LEN;
                    d12_d   = {data2, data1};
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            READ2: begin
                if (phase_q == '0) begin
                    state_d       = IDLE;
                    frame_data_d  = {data4, data3, d12_q};
                    frame_valid_d = 1'b1;
                end else begin
                    phase_d = phase_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        erase_d  = (state_d == ERASE);
        expose_d = (state_d == EXPOSE);
        ramp_d   = (state_d == CONVERT);
        read1_d  = (state_d == READ1);
        read2_d  = (state_d == READ2);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            exp_q         <= '0;
            d12_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            erase_q       <= 1'b0;
            expose_q      <= 1'b0;
            read1_q       <= 1'b0;
            read2_q       <= 1'b0;
            ramp_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            exp_q         <= exp_d;
            d12_q         <= d12_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            erase_q       <= erase_d;
            expose_q      <= expose_d;
            read1_q       <= read1_d;
            read2_q       <= read2_d;
            ramp_q        <= ramp_d;
            busy_q        <= busy_d;
        end
    end

    adc_counter #(.DW(DW)) u_adc (
        .clk    (clk),
        .reset  (reset),
        .clear  (adc_clear),
        .enable (adc_en),
        .count  (adc_count)
    );

    assign erase           = erase_q;
    assign expose          = expose_q;
    assign read1           = read1_q;
    assign read2           = read2_q;
    assign ramp_en         = ramp_q;
    assign cnt_oe          = ramp_q;
    assign cnt_out         = adc_count;
    assign cap.busy        = busy_q;
    assign cap.frame_data  = frame_data_q;
    assign cap.frame_valid = frame_valid_q;
    assign dbg_state       = state_q;
endmodule
